// File: rtl/booth_seq_mult.sv
// Iterative radix-2 Booth multiplier: one recode/add/shift step per clock, signed WIDTH x WIDTH -> 2*WIDTH.
// Optional build macro BOOTH_EARLY_TERM_EN finishes as soon as the remaining recodes are all no-ops.
module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    // state | meaning
    // IDLE  | waiting for start
    // CALC  | WIDTH Booth steps, then one cycle to register the product
    // DONE  | product valid for one cycle; a new start is accepted here
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH:0]     m, m_nxt;
    logic [WIDTH:0]     acc, acc_nxt;
    logic [WIDTH-1:0]   q, q_nxt;
    logic               q_m1, q_m1_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH:0]     acc_sel;
`ifdef BOOTH_EARLY_TERM_EN
    logic [WIDTH-1:0]   rem_mask;
    logic [2*WIDTH:0]   full_shr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state   <= state_nxt;
            m       <= m_nxt;
            acc     <= acc_nxt;
            q       <= q_nxt;
            q_m1    <= q_m1_nxt;
            cnt     <= cnt_nxt;
            product <= prod_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        m_nxt     = m;
        acc_nxt   = acc;
        q_nxt     = q;
        q_m1_nxt  = q_m1;
        cnt_nxt   = cnt;
        prod_nxt  = product;
        busy      = 1'b0;
        done      = 1'b0;
        acc_sel   = acc;
`ifdef BOOTH_EARLY_TERM_EN
        rem_mask  = '0;
        full_shr  = '0;
`endif
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    m_nxt     = {a[WIDTH-1], a};
                    acc_nxt   = '0;
                    q_nxt     = b;
                    q_m1_nxt  = 1'b0;
                    cnt_nxt   = CNT_W'(WIDTH);
                    state_nxt = CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    prod_nxt  = {acc[WIDTH-1:0], q};
                    state_nxt = DONE;
                end else begin
                    case ({q[0], q_m1})
                        2'b10:   acc_sel = acc - m;
                        2'b01:   acc_sel = acc + m;
                        default: acc_sel = acc;
                    endcase
                    acc_nxt  = {acc_sel[WIDTH], acc_sel[WIDTH:1]};
                    q_nxt    = {acc_sel[0], q[WIDTH-1:1]};
                    q_m1_nxt = q[0];
                    cnt_nxt  = cnt - CNT_W'(1);
`ifdef BOOTH_EARLY_TERM_EN
                    // Unprocessed multiplier bits sit in the low cnt_nxt bits of Q; if they all
                    // match q_m1 every remaining recode is a no-op and only the shifts remain.
                    rem_mask = ~({WIDTH{1'b1}} << cnt_nxt);
                    full_shr = $signed({acc_nxt, q_nxt}) >>> cnt_nxt;
                    if (cnt_nxt != '0 && ((q_nxt ^ {WIDTH{q_m1_nxt}}) & rem_mask) == '0) begin
                        prod_nxt  = full_shr[2*WIDTH-1:0];
                        state_nxt = DONE;
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_booth_seq_mult.sv
// Scoreboard bench for booth_seq_mult (WIDTH=8): driver pushes expected product and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_booth_seq_mult;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a, b;
    logic           busy, done;
    logic [2*W-1:0] product;

    typedef struct {
        logic [2*W-1:0] prod;
        int             at;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    booth_seq_mult #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares each done pulse against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got done with empty scoreboard, required none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", 32'(product), 32'(e.prod));
                if (e.at >= 0) check("done_cycle", cyc, e.at);
            end
        end
    end

    // Called right after a negedge; returns at the next negedge.
    task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic [2*W-1:0] exp, input int lat);
        exp_t e;
        a     = aa;
        b     = bb;
        start = 1'b1;
        e.prod = exp;
        e.at   = (lat < 0) ? -1 : cyc + lat + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL done_timeout: got no done within 40 cycles, required a done pulse");
        end
    endtask

    int lat_fix;
    logic signed [W-1:0]   sa, sbb;
    logic signed [2*W-1:0] sp;

    initial begin
        lat_fix = W + 1;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_product", 32'(product), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 3*5 with cycle-by-cycle busy/done profile
        issue(8'd3, 8'd5, 16'h000F, lat_fix);
        for (int i = 0; i < W + 1; i++) begin
            check("busy_calc", 32'(busy), 1);
            check("done_calc", 32'(done), 0);
            @(negedge clk);
        end
        check("done_pulse", 32'(done), 1);
        check("busy_in_done", 32'(busy), 0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 0);
        check("product_held", 32'(product), 32'h000F);

        // back-to-back: second start issued in the done cycle of the first
        issue(8'hF9, 8'd6, 16'hFFD6, lat_fix);
        wait_done();
        issue(8'd127, 8'h80, 16'hC080, lat_fix);
        wait_done();
        issue(8'h80, 8'h80, 16'h4000, lat_fix);
        wait_done();
        issue(8'd0, 8'hFF, 16'h0000, lat_fix);
        wait_done();

        // start while busy must be ignored
        issue(8'd5, 8'hFD, 16'hFFF1, lat_fix);
        repeat (2) @(negedge clk);
        a = 8'd1;
        b = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (15) @(negedge clk);
        check("product_after_ignored", 32'(product), 32'hFFF1);

`ifdef BOOTH_EARLY_TERM_EN
        issue(8'd100, 8'd1, 16'h0064, 2);
`else
        issue(8'd100, 8'd1, 16'h0064, lat_fix);
`endif
        wait_done();
        @(negedge clk);

        // reset mid-CALC: no done pulse afterwards, product cleared
        a = 8'd9;
        b = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_product", 32'(product), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("post_reset_product", 32'(product), 0);

        // random signed sweep against a*b
        for (int i = 0; i < 1000; i++) begin
            sa  = W'($urandom);
            sbb = W'($urandom);
            sp  = sa * sbb;
`ifdef BOOTH_EARLY_TERM_EN
            issue(sa, sbb, sp, -1);
`else
            issue(sa, sbb, sp, lat_fix);
`endif
            wait_done();
        end

        begin
            int k = 0;
            while (sb.size() != 0 && k < 40) begin
                @(negedge clk);
                k++;
            end
            if (sb.size() != 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL drain: got %0d outstanding results, required 0", sb.size());
            end
        end
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
